mod_reduce_seq: RTL and testbench



---
 rtl/mod_reduce_seq.sv | 93 +++++++++
 tb/tb_mod_reduce_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - sequential X mod M residue engine, one K-bit chunk folded per cycle (Horner, MSB first).
// Optional out_zero flag compiled in with MODRED_ZERO_FLAG_EN.
module mod_reduce_seq #(
  parameter int XW = 100,
  parameter int M  = 461,
  parameter int K  = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef MODRED_ZERO_FLAG_EN
  output logic          out_zero,
`endif
  output logic [K-1:0]  out_r
);

  localparam int N     = (XW + K - 1) / K;
  localparam int NK    = N * K;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int TW    = 2 * K + 2;
  localparam int FOLDS = 2 * K + 2;
  localparam longint unsigned C_L = (64'd1 << K) % M;
  localparam logic [TW-1:0] C_T = TW'(C_L);
  localparam logic [TW-1:0] M_T = TW'(M);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t        state, state_n;
  logic [NK-1:0] x_q;
  logic [K-1:0]  acc;
  logic [K-1:0]  acc_n;
  logic [IW-1:0] idx;
  logic [K-1:0]  chunk;
  logic [TW-1:0] t;

  // Each fold replaces hi*2^K by hi*C, i.e. subtracts hi*M, so it never
  // increases the value and stops once the high part is zero.
  always_comb begin
    chunk = x_q[idx*K +: K];
    t     = TW'(acc) * C_T + TW'(chunk);
    for (int i = 0; i < FOLDS; i++) begin
      if (t[TW-1:K] != '0)
        t = TW'(t[K-1:0]) + TW'(t[TW-1:K]) * C_T;
    end
    if (t >= M_T)
      t = t - M_T;
    acc_n = t[K-1:0];
  end

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_n = FOLD;
      FOLD: if (idx == '0) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      x_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        x_q <= NK'(in_x);
        acc <= '0;
        idx <= IDX_TOP;
      end else if (state == FOLD) begin
        acc <= acc_n;
        if (idx != '0)
          idx <= idx - 1'b1;
      end
    end
  end

  assign out_r = acc;

`ifdef MODRED_ZERO_FLAG_EN
  assign out_zero = (acc == '0);
`endif

endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb/tb_mod_reduce_seq.sv - directed and short random checks of mod_reduce_seq at default parameters.
module tb_mod_reduce_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [99:0]  in_x;
  logic         out_valid;
  logic         out_ready;
  logic [8:0]   out_r;
`ifdef MODRED_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MODRED_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .out_r     (out_r)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept x, wait for the residue, optionally stall gap cycles, then handshake.
  task automatic run_op(input string tag, input logic [99:0] x, input logic [8:0] exp, input int gap);
    int n;
    in_x      = x;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    check(tag, out_r, exp);
`ifdef MODRED_ZERO_FLAG_EN
    check({tag, "_zero"}, out_zero, exp == 0);
`endif
    for (int i = 0; i < gap; i++) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [127:0] rx;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_r", out_r, 9'd0);
`ifdef MODRED_ZERO_FLAG_EN
    check("rst_out_zero", out_zero, 1'b1);
`endif

    // Exact latency: out_valid must first appear 12 edges after accept.
    in_x      = 100'd1000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_x     = 100'd5;
    check("lat_in_ready_low", in_ready, 1'b0);
    for (int i = 1; i < 12; i++) begin
      check("lat_no_valid", out_valid, 1'b0);
      step();
    end
    check("lat_no_valid_11", out_valid, 1'b0);
    step();
    check("lat_valid_12", out_valid, 1'b1);
    check("lat_r_1000", out_r, 9'd78);
    step();
    check("lat_in_ready_back", in_ready, 1'b1);
    check("lat_valid_clear", out_valid, 1'b0);
    out_ready = 1'b0;

    run_op("r_461", 100'd461, 9'd0, 0);
    run_op("r_460", 100'd460, 9'd460, 1);
    run_op("r_zero", 100'd0, 9'd0, 0);
    run_op("r_pow99", 100'd1 << 99, 9'd200, 2);
    run_op("r_ones", {100{1'b1}}, 9'd399, 0);
    run_op("r_mult", 100'd461000, 9'd0, 0);
    run_op("r_123456789", 100'd123456789, 9'd67, 0);

    // Backpressure with a competing operand on the input.
    in_x      = 100'd123456789;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_x = 100'd5;
    for (int i = 0; i < 30 && !out_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_r", out_r, 9'd67);
      check("bp_in_ready", in_ready, 1'b0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_in_ready", in_ready, 1'b1);
    step();
    check("bp_idle_hold", in_ready, 1'b1);

    // Reset in the middle of a fold.
    in_x     = {100{1'b1}};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_r", out_r, 9'd0);
    run_op("post_rst_1000", 100'd1000, 9'd78, 0);

    for (int n = 0; n < 30; n++) begin
      rx = {$urandom, $urandom, $urandom, $urandom};
      rx[127:100] = '0;
      if (n % 3 == 1) rx = rx >> $urandom_range(0, 90);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      run_op("rand", rx[99:0], 9'(rx % 128'd461), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
